// File: rtl/dcache_param.sv
// Direct-mapped write-back data cache with a line req/ack port, flush and counters.
// cpu_* side: read/write/addr/wdata/rdata/stall; mem_* side: req/we/addr/wdata/rdata/ack.
module dcache_param #(
  parameter int DSIZE      = 16,
  parameter int ASIZE      = 16,
  parameter int LINE_WORDS = 16,
  parameter int NUM_LINES  = 16,
  parameter int CNT_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cpu_read,
  input  logic                                 cpu_write,
  input  logic [ASIZE-1:0]                     cpu_addr,
  input  logic [DSIZE-1:0]                     cpu_wdata,
  output logic [DSIZE-1:0]                     cpu_rdata,
  output logic                                 stall,
  input  logic                                 flush_req,
  output logic                                 flush_done,
  output logic                                 mem_req,
  output logic                                 mem_we,
  output logic [ASIZE-$clog2(LINE_WORDS)-1:0]  mem_addr,
  output logic [LINE_WORDS*DSIZE-1:0]          mem_wdata,
  input  logic [LINE_WORDS*DSIZE-1:0]          mem_rdata,
  input  logic                                 mem_ack,
  output logic [CNT_W-1:0]                     hit_cnt,
  output logic [CNT_W-1:0]                     miss_cnt
);

  localparam int OFF = $clog2(LINE_WORDS);
  localparam int IDX = $clog2(NUM_LINES);
  localparam int TAG = ASIZE - IDX - OFF;
  localparam int LW  = LINE_WORDS * DSIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_FL_SCAN,
    S_FL_WB
  } state_e;

  state_e state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG-1:0]       tag_q  [NUM_LINES];
  logic [LW-1:0]        data_q [NUM_LINES];

  logic [IDX-1:0]   idx_q, idx_d;
  logic [TAG-1:0]   rtag_q, rtag_d;
  logic             fill_q, fill_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  logic [TAG-1:0]   a_tag;
  logic [IDX-1:0]   a_idx;
  logic [OFF-1:0]   a_off;
  logic             req;
  logic             hit;
  logic             vic_dirty;
  logic [DSIZE-1:0] rd_word;
  logic             wr_en;
  logic             fill_en;
  logic             clr_en;

  assign a_tag     = cpu_addr[ASIZE-1 -: TAG];
  assign a_idx     = cpu_addr[OFF +: IDX];
  assign a_off     = cpu_addr[OFF-1:0];
  assign req       = cpu_read | cpu_write;
  assign hit       = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign vic_dirty = valid_q[a_idx] & dirty_q[a_idx];
  assign rd_word   = data_q[a_idx][int'(a_off)*DSIZE +: DSIZE];

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rtag_d     = rtag_q;
    fill_d     = fill_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    stall      = 1'b1;
    cpu_rdata  = '0;
    flush_done = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_en      = 1'b0;
    fill_en    = 1'b0;
    clr_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall  = 1'b0;
        fill_d = 1'b0;
        if (req) begin
          if (hit) begin
            cpu_rdata = rd_word;
            wr_en     = cpu_write;
            // the access that finishes a fill is not a new hit
            if (!fill_q && hit_q != '1)
              hit_d = hit_q + 1'b1;
          end else begin
            stall  = 1'b1;
            idx_d  = a_idx;
            rtag_d = a_tag;
            if (miss_q != '1)
              miss_d = miss_q + 1'b1;
            state_d = vic_dirty ? S_WB : S_FILL;
          end
        end else if (flush_req) begin
          idx_d   = '0;
          state_d = S_FL_SCAN;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[idx_q], idx_q};
        mem_wdata = data_q[idx_q];
        if (mem_ack)
          state_d = S_FILL;
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {rtag_q, idx_q};
        if (mem_ack) begin
          fill_en = 1'b1;
          fill_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FL_SCAN: begin
        if (valid_q[idx_q] & dirty_q[idx_q]) begin
          state_d = S_FL_WB;
        end else if (&idx_q) begin
          flush_done = 1'b1;
          state_d    = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_FL_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[idx_q], idx_q};
        mem_wdata = data_q[idx_q];
        if (mem_ack) begin
          clr_en  = 1'b1;
          state_d = S_FL_SCAN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rtag_q  <= '0;
      fill_q  <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rtag_q  <= rtag_d;
      fill_q  <= fill_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      if (fill_en) begin
        valid_q[idx_q] <= 1'b1;
        dirty_q[idx_q] <= 1'b0;
      end
      if (wr_en)
        dirty_q[a_idx] <= 1'b1;
      if (clr_en)
        dirty_q[idx_q] <= 1'b0;
    end
  end

  // tag/data arrays carry no reset; valid bits guard them
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_en) begin
        tag_q[idx_q]  <= rtag_q;
        data_q[idx_q] <= mem_rdata;
      end
      if (wr_en)
        data_q[a_idx][int'(a_off)*DSIZE +: DSIZE] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_param.sv
// Bench for dcache_param: random loads/stores/flushes vs. a memory-level model.
// Expected reads and line transfers are queued and checked by monitor/responder.
module tb_dcache_param;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, cpu_read, cpu_write, flush_req, mem_ack;
  logic [15:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          stall, flush_done, mem_req, mem_we;
  logic [11:0]   mem_addr;
  logic [255:0]  mem_wdata, mem_rdata;
  logic [CW-1:0] hit_cnt, miss_cnt;

  dcache_param #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .flush_req (flush_req),
    .flush_done(flush_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         we;
    logic [11:0]  a;
    logic [255:0] d;
  } txn_t;

  int checks = 0;
  int failures = 0;
  int flush_pulses = 0;
  int exp_hit, exp_miss;
  int exp_flush = 0;
  bit manual = 1'b0;
  int forced_lat = -1;

  logic [15:0] bmem [65536];
  logic [15:0] rmem [65536];
  bit          dv [16];
  bit          dd [16];
  logic [7:0]  dt [16];
  txn_t        mq [$];
  logic [15:0] rq [$];

  task automatic chk(input bit ok, input string nm,
                     input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input int a);
    return 16'(a * 40503 + 17) ^ 16'h5A3C;
  endfunction

  function automatic int sat(input int v);
    return (v < (1 << CW) - 1) ? v + 1 : v;
  endfunction

  function automatic logic [255:0] rline(input logic [11:0] la);
    logic [255:0] r;
    r = '0;
    for (int w = 0; w < 16; w++) r[w*16 +: 16] = rmem[{la, 4'(w)}];
    return r;
  endfunction

  function automatic logic [255:0] bline(input logic [11:0] la);
    logic [255:0] r;
    r = '0;
    for (int w = 0; w < 16; w++) r[w*16 +: 16] = bmem[{la, 4'(w)}];
    return r;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 16; i++) begin
      dv[i] = 1'b0;
      dd[i] = 1'b0;
      dt[i] = '0;
    end
    exp_hit = 0;
    exp_miss = 0;
    for (int a = 0; a < 65536; a++) rmem[a] = bmem[a];
  endtask

  // architectural view: a cached line always equals memory as the CPU sees it
  task automatic model_access(input bit we, input logic [15:0] a,
                              input logic [15:0] d);
    logic [3:0] ix;
    logic [7:0] tg;
    txn_t t;
    ix = a[7:4];
    tg = a[15:8];
    if (dv[ix] && dt[ix] == tg) begin
      exp_hit = sat(exp_hit);
    end else begin
      if (dv[ix] && dd[ix]) begin
        t.we = 1'b1;
        t.a  = {dt[ix], ix};
        t.d  = rline({dt[ix], ix});
        mq.push_back(t);
      end
      t.we = 1'b0;
      t.a  = a[15:4];
      t.d  = '0;
      mq.push_back(t);
      exp_miss = sat(exp_miss);
      dv[ix] = 1'b1;
      dt[ix] = tg;
      dd[ix] = 1'b0;
    end
    if (we) begin
      rmem[a] = d;
      dd[ix] = 1'b1;
    end else begin
      rq.push_back(rmem[a]);
    end
  endtask

  task automatic do_op(input bit we, input logic [15:0] a,
                       input logic [15:0] d, output int st);
    model_access(we, a, d);
    @(posedge clk); #1;
    cpu_read  = !we;
    cpu_write = we;
    cpu_addr  = a;
    cpu_wdata = d;
    st = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      st++;
      if (st > 100) begin
        chk(1'b0, "op_timeout", 256'(st), 256'd100);
        break;
      end
    end
    @(posedge clk); #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic do_flush();
    int nwb;
    int cyc;
    txn_t t;
    nwb = 0;
    for (int i = 0; i < 16; i++) begin
      if (dv[i] && dd[i]) begin
        t.we = 1'b1;
        t.a  = {dt[i], 4'(i)};
        t.d  = rline({dt[i], 4'(i)});
        mq.push_back(t);
        dd[i] = 1'b0;
        nwb++;
      end
    end
    exp_flush++;
    @(posedge clk); #1;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (flush_done) break;
      if (cyc > 2000) begin
        chk(1'b0, "flush_timeout", 256'(cyc), 256'd2000);
        break;
      end
    end
    if (nwb == 0) chk(cyc == 16, "clean_flush_lat", 256'(cyc), 256'd16);
  endtask

  task automatic chk_cnts(input string nm);
    chk(hit_cnt == CW'(exp_hit) && miss_cnt == CW'(exp_miss), nm,
        256'({hit_cnt, miss_cnt}), 256'({CW'(exp_hit), CW'(exp_miss)}));
  endtask

  // backing memory: serves line requests with a variable ack latency
  initial begin : responder
    bit busy;
    int cnt, lat;
    logic cwe;
    logic [11:0] ca;
    logic [255:0] cd;
    txn_t e;
    busy = 1'b0;
    cnt = 0;
    lat = 0;
    cwe = 1'b0;
    ca = '0;
    cd = '0;
    forever begin
      @(posedge clk); #1;
      if (manual) begin
        busy = 1'b0;
        continue;
      end
      mem_ack = 1'b0;
      if (rst) begin
        busy = 1'b0;
        continue;
      end
      if (!busy && mem_req) begin
        if (mq.size() == 0) begin
          chk(1'b0, "unexpected_req", 256'({mem_we, mem_addr}), 256'd0);
        end else begin
          e = mq.pop_front();
          chk(mem_we == e.we && mem_addr == e.a, "req_kind_addr",
              256'({mem_we, mem_addr}), 256'({e.we, e.a}));
          if (e.we) chk(mem_wdata == e.d, "wb_data", mem_wdata, e.d);
        end
        busy = 1'b1;
        cnt = 0;
        lat = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 4));
        cwe = mem_we;
        ca = mem_addr;
        cd = mem_wdata;
        if (!mem_we) mem_rdata = bline(mem_addr);
      end
      if (busy) begin
        if (cnt == lat) begin
          chk(mem_req && mem_we == cwe && mem_addr == ca &&
              (!cwe || mem_wdata == cd), "req_stable",
              256'({mem_req, mem_we, mem_addr}), 256'({1'b1, cwe, ca}));
          mem_ack = 1'b1;
          if (cwe)
            for (int w = 0; w < 16; w++) bmem[{ca, 4'(w)}] = cd[w*16 +: 16];
          busy = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cpu_read && !cpu_write && !stall) begin
          if (rq.size() == 0) begin
            chk(1'b0, "rdata_unexpected", 256'(cpu_rdata), 256'd0);
          end else begin
            e = rq.pop_front();
            chk(cpu_rdata == e, "rdata", 256'(cpu_rdata), 256'(e));
          end
        end
        if (!stall)
          chk(!mem_req && !mem_we && mem_addr == '0 && mem_wdata == '0,
              "idle_mem_zero", 256'({mem_req, mem_we, mem_addr}), 256'd0);
        if (flush_done) flush_pulses++;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int st;
    logic [7:0] tags [4];
    logic [15:0] a;
    rst = 1'b1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    flush_req = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    tags[0] = 8'h01;
    tags[1] = 8'h05;
    tags[2] = 8'h12;
    tags[3] = 8'h40;
    for (int i = 0; i < 65536; i++) bmem[i] = init_word(i);
    bmem[16'h0123] = 16'hBEEF;
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(!stall && cpu_rdata == '0 && !flush_done && !mem_req &&
        hit_cnt == '0 && miss_cnt == '0, "reset_state",
        256'({stall, cpu_rdata, flush_done, mem_req, hit_cnt, miss_cnt}),
        256'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // clean read miss, ack two cycles after req
    forced_lat = 2;
    do_op(1'b0, 16'h0123, 16'h0, st);
    forced_lat = -1;
    chk(st == 4, "clean_miss_stall", 256'(st), 256'd4);
    chk_cnts("cnt_after_miss");

    // write hit then read hit
    do_op(1'b1, 16'h0125, 16'h1234, st);
    chk(st == 0, "write_hit_stall", 256'(st), 256'd0);
    do_op(1'b0, 16'h0125, 16'h0, st);
    chk(st == 0, "read_hit_stall", 256'(st), 256'd0);
    chk_cnts("cnt_after_hits");

    // conflict miss evicts the dirty line
    do_op(1'b0, 16'h0523, 16'h0, st);
    chk_cnts("cnt_after_evict");

    // flush with two dirty lines, then a flush of a clean cache
    do_op(1'b1, 16'h0310, 16'hA1A1, st);
    do_op(1'b1, 16'h0770, 16'h7777, st);
    do_flush();
    chk(mq.size() == 0, "flush_wb_done", 256'(mq.size()), 256'd0);
    do_flush();
    chk(flush_pulses == exp_flush, "flush_pulses",
        256'(flush_pulses), 256'(exp_flush));

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        do_flush();
      end else begin
        a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15))};
        do_op(1'($urandom_range(0, 1)), a, 16'($urandom), st);
      end
    end
    chk_cnts("cnt_after_random");
    chk(mq.size() == 0 && rq.size() == 0, "queues_after_random",
        256'(mq.size() + rq.size()), 256'd0);

    // reset while a fill is outstanding
    manual = 1'b1;
    @(posedge clk); #1;
    cpu_read = 1'b1;
    cpu_addr = 16'h0A40;
    st = 0;
    forever begin
      @(negedge clk);
      if (mem_req) break;
      st++;
      if (st > 20) begin
        chk(1'b0, "fill_req_timeout", 256'(st), 256'd20);
        break;
      end
    end
    chk(mem_req && !mem_we && mem_addr == 12'h0A4, "fill_req",
        256'({mem_req, mem_we, mem_addr}), 256'({2'b10, 12'h0A4}));
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(!mem_req && !stall && miss_cnt == '0 && hit_cnt == '0,
        "after_reset", 256'({mem_req, stall, hit_cnt, miss_cnt}), 256'd0);
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk(!mem_req && !stall && miss_cnt == '0, "late_ack_ignored",
        256'({mem_req, stall, miss_cnt}), 256'd0);
    reset_model();
    manual = 1'b0;
    do_op(1'b0, 16'h0A40, 16'h0, st);
    chk(st > 0, "reread_misses", 256'(st), 256'd1);
    chk_cnts("cnt_after_reread");

    // saturation of the miss counter
    for (int i = 0; i < 20; i++) begin
      a = {8'(8'h10 + i), 8'h30};
      do_op(1'b0, a, 16'h0, st);
    end
    chk(miss_cnt == 4'hF, "miss_saturated", 256'(miss_cnt), 256'hF);
    chk_cnts("cnt_final");
    chk(mq.size() == 0 && rq.size() == 0, "queues_final",
        256'(mq.size() + rq.size()), 256'd0);
    chk(flush_pulses == exp_flush, "flush_pulses_final",
        256'(flush_pulses), 256'(exp_flush));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
